// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb_pkg                                                |
// | Description : Shared AHB-Lite encodings, error-FSM state type and    |
// |               little-endian byte-strobe helper for ahb_sram_if.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ahb_pkg;

  // Transfer type encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // Transfer size encodings
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Response encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Two-cycle ERROR response sequencer states
  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_state_t;

  // Byte lanes touched by a transfer; unsupported sizes touch nothing
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] offset);
    logic [3:0] r_lanes;
    r_lanes = 4'b0000;
    case (size)
      HSIZE_BYTE: r_lanes = 4'b0001 << offset;
      HSIZE_HALF: r_lanes = 4'b0011 << offset;
      HSIZE_WORD: r_lanes = 4'b1111;
      default:    r_lanes = 4'b0000;
    endcase
    return r_lanes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb_sram_wbuf                                          |
// | Description : Single-entry write buffer holding one deferred SRAM    |
// |               write, with byte-wise forwarding into read data.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ahb_sram_wbuf
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_drain,
  input  logic [ADDR_BITS-1:0] i_load_addr,
  input  logic [3:0]           i_load_wbe,
  input  logic [DATA_BITS-1:0] i_load_data,
  input  logic [ADDR_BITS-1:0] i_fwd_addr,
  input  logic [DATA_BITS-1:0] i_fwd_data,
  output logic                 o_valid,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [3:0]           o_wbe,
  output logic [DATA_BITS-1:0] o_data,
  output logic [DATA_BITS-1:0] o_fwd_data
);

  logic                 r_valid;
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_wbe;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_hit;

  // Capture a deferred write on load; release it once it has been drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wbe   <= 4'b0000;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_load_addr;
      r_wbe   <= i_load_wbe;
      r_data  <= i_load_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign w_hit      = r_valid && (r_addr == i_fwd_addr);
  assign o_valid    = r_valid;
  assign o_addr     = r_addr;
  assign o_wbe      = r_wbe;
  assign o_data     = r_data;

  // Per-lane merge: buffered bytes override stale SRAM bytes on a hit
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign o_fwd_data[8*g +: 8] = (w_hit && r_wbe[g]) ? r_data[8*g +: 8]
                                                      : i_fwd_data[8*g +: 8];
  end

  // Only one write may ever be parked here
  a_no_overload : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(i_load && r_valid));

endmodule
`default_nettype wire

// File: rtl/ahb_sram_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb_sram_if                                            |
// | Description : Zero-wait AHB-Lite slave in front of a single-port     |
// |               byte-enabled SRAM; write buffer resolves port clashes, |
// |               illegal transfers get a two-cycle ERROR response.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ahb_sram_if
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS   = 7,
  parameter int ADDR_AMOUNT = 128,
  parameter int DATA_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [DATA_BITS-1:0] hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [DATA_BITS-1:0] hrdata,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [3:0]           sram_wbe,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_din,
  input  logic [DATA_BITS-1:0] sram_dout
);

  localparam logic [31:0] c_ADDR_LIMIT = 32'(ADDR_AMOUNT);

  // Address-phase decode
  logic                 w_active;
  logic                 w_illegal;
  logic [3:0]           w_strobe;
  logic [ADDR_BITS-1:0] w_ap_waddr;
  logic                 w_rd_ap;
  logic                 w_wr_ap;
  logic                 w_err_ap;

  // Data-phase registers
  logic                 r_dp_rd;
  logic                 r_dp_wr;
  logic [ADDR_BITS-1:0] r_dp_addr;
  logic [3:0]           r_dp_wbe;

  // Error sequencer
  err_state_t           r_state;
  err_state_t           w_state_next;

  // Write path control
  logic                 w_direct;
  logic                 w_load;
  logic                 w_drain;
  logic                 w_buf_valid;
  logic [ADDR_BITS-1:0] w_buf_addr;
  logic [3:0]           w_buf_wbe;
  logic [DATA_BITS-1:0] w_buf_data;
  logic [DATA_BITS-1:0] w_fwd_data;

  assign w_active   = hsel && hready &&
                      (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
  assign w_strobe   = byte_strobe(hsize, haddr[1:0]);
  assign w_ap_waddr = haddr[ADDR_BITS+1:2];

  assign w_illegal  = (hsize > HSIZE_WORD) ||
                      ((hsize == HSIZE_HALF) && haddr[0]) ||
                      ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                      ({2'b00, haddr[31:2]} >= c_ADDR_LIMIT);

  assign w_rd_ap  = w_active && !hwrite && !w_illegal;
  assign w_wr_ap  = w_active &&  hwrite && !w_illegal;
  assign w_err_ap = w_active &&  w_illegal;

  // A read address phase owns the SRAM; a pending write either waits in
  // the buffer or goes straight out when the port is free.
  assign w_direct = r_dp_wr && !w_rd_ap;
  assign w_load   = r_dp_wr &&  w_rd_ap;
  assign w_drain  = w_buf_valid && !w_rd_ap;

  // Register the accepted address phase for use in the data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_rd   <= 1'b0;
      r_dp_wr   <= 1'b0;
      r_dp_addr <= '0;
      r_dp_wbe  <= 4'b0000;
    end else if (hready) begin
      r_dp_rd <= w_rd_ap;
      r_dp_wr <= w_wr_ap;
      if (w_rd_ap || w_wr_ap) begin
        r_dp_addr <= w_ap_waddr;
        r_dp_wbe  <= w_strobe;
      end
    end
  end

  // Error sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ERR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Error sequencer next state and bus response
  always_comb begin
    w_state_next = r_state;
    hreadyout    = 1'b1;
    hresp        = HRESP_OKAY;
    case (r_state)
      ERR_IDLE: begin
        if (w_err_ap) w_state_next = ERR_1;
      end
      ERR_1: begin
        hreadyout    = 1'b0;
        hresp        = HRESP_ERROR;
        w_state_next = ERR_2;
      end
      ERR_2: begin
        hresp        = HRESP_ERROR;
        w_state_next = w_err_ap ? ERR_1 : ERR_IDLE;
      end
      default: begin
        w_state_next = ERR_IDLE;
      end
    endcase
  end

  ahb_sram_wbuf #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_drain     (w_drain),
    .i_load_addr (r_dp_addr),
    .i_load_wbe  (r_dp_wbe),
    .i_load_data (hwdata),
    .i_fwd_addr  (r_dp_addr),
    .i_fwd_data  (sram_dout),
    .o_valid     (w_buf_valid),
    .o_addr      (w_buf_addr),
    .o_wbe       (w_buf_wbe),
    .o_data      (w_buf_data),
    .o_fwd_data  (w_fwd_data)
  );

  // SRAM port mux: read address phase first, then direct write or drain
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_wbe  = 4'b0000;
    sram_addr = '0;
    sram_din  = '0;
    if (w_rd_ap) begin
      sram_en   = 1'b1;
      sram_addr = w_ap_waddr;
    end else if (w_direct) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_wbe  = r_dp_wbe;
      sram_addr = r_dp_addr;
      sram_din  = hwdata;
    end else if (w_drain) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_wbe  = w_buf_wbe;
      sram_addr = w_buf_addr;
      sram_din  = w_buf_data;
    end
  end

  assign hrdata = r_dp_rd ? w_fwd_data : '0;

  // A direct write and a drain can never both want the port
  a_one_writer : assert property (@(posedge clk) disable iff (!rst_n)
                                  !(w_direct && w_drain));

  // Only the read address phase may claim the port alongside nothing else
  a_one_user : assert property (@(posedge clk) disable iff (!rst_n)
                                !(w_rd_ap && sram_we));

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ahb_sram_if                                         |
// | Description : Self-checking bench for ahb_sram_if with SRAM model,   |
// |               reference memory and response scoreboard.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ahb_sram_if;

  localparam int K_IDLE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        sram_en;
  logic        sram_we;
  logic [3:0]  sram_wbe;
  logic [6:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = 32'h0;

  always #5 clk = ~clk;

  // Single-slave system: the bus ready is this slave's ready
  assign hready = hreadyout;

  ahb_sram_if #(
    .ADDR_BITS   (7),
    .ADDR_AMOUNT (128),
    .DATA_BITS   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_wbe  (sram_wbe),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Synchronous SRAM model, one-cycle read latency, not reset
  logic [31:0] mem [0:127] = '{default: 32'h0};
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wbe[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
  } op_t;

  typedef struct {
    int          kind;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [0:127];
  int          errors = 0;
  int          checks = 0;
  int          err_cyc = 0;
  logic        snap_en, snap_we, err1_en;
  logic [3:0]  snap_wbe;
  logic [6:0]  snap_addr;
  logic [31:0] snap_din;
  logic [31:0] saved8;
  op_t         vec [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tb_illegal(input logic [2:0] size, input logic [31:0] a);
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && a[0]) return 1'b1;
    if (size == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    if (a[31:2] >= 30'd128) return 1'b1;
    return 1'b0;
  endfunction

  function automatic op_t mk(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                             input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.trans   = trans;
    o.wr      = wr;
    o.size    = size;
    o.addr    = a;
    o.wdata   = d;
    o.exp_err = trans[1] && tb_illegal(size, a);
    return o;
  endfunction

  task automatic ref_write(input logic [2:0] size, input logic [31:0] a, input logic [31:0] d);
    int off;
    int n;
    off = int'(a[1:0]);
    n   = 1 << size;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) ref_mem[a[8:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // One bus beat: drive address phase, check the current data phase,
  // record the next expectation once the address phase is accepted.
  task automatic step(input op_t op);
    exp_t e;
    exp_t n;
    bit   done;
    done = 1'b0;
    for (int tries = 0; tries < 4 && !done; tries++) begin
      hsel   = (op.trans != 2'b00);
      htrans = op.trans;
      haddr  = op.addr;
      hwrite = op.wr;
      hsize  = op.size;
      hwdata = (sbq.size() > 0 && sbq[0].kind == K_WR) ? sbq[0].wdata : 32'hDEAD_BEEF;
      @(negedge clk);
      snap_en   = sram_en;
      snap_we   = sram_we;
      snap_wbe  = sram_wbe;
      snap_addr = sram_addr;
      snap_din  = sram_din;
      if (sbq.size() > 0) begin
        e = sbq[0];
        if (e.kind == K_ERR) begin
          if (err_cyc == 0) begin
            chk("err1_hreadyout", 32'(hreadyout), 32'd0);
            chk("err1_hresp", 32'(hresp), 32'd1);
            err1_en = sram_en;
            err_cyc = 1;
          end else begin
            chk("err2_hreadyout", 32'(hreadyout), 32'd1);
            chk("err2_hresp", 32'(hresp), 32'd1);
            void'(sbq.pop_front());
            err_cyc = 0;
          end
        end else begin
          chk("ok_hreadyout", 32'(hreadyout), 32'd1);
          chk("ok_hresp", 32'(hresp), 32'd0);
          chk(e.kind == K_RD ? "rd_hrdata" : "nonrd_hrdata", hrdata, e.rdata);
          void'(sbq.pop_front());
        end
      end
      if (hreadyout) begin
        done    = 1'b1;
        n.rdata = 32'h0;
        n.wdata = op.wdata;
        if (!op.trans[1]) begin
          n.kind = K_IDLE;
        end else if (op.exp_err) begin
          n.kind = K_ERR;
        end else if (op.wr) begin
          n.kind = K_WR;
          ref_write(op.size, op.addr, op.wdata);
        end else begin
          n.kind  = K_RD;
          n.rdata = ref_mem[op.addr[8:2]];
        end
        sbq.push_back(n);
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: address %h never accepted", op.addr);
    end
  endtask

  task automatic idle();
    step(mk(2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nmis;
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;

    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    hwdata = 32'h0; rst_n = 1'b0; err1_en = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;

    // Reset state
    #12;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: word write goes direct, read back after a gap
    step(mk(2'b10, 1'b1, 3'd2, 32'h00, 32'h1122_3344));
    idle();
    chk("t1_direct_en", 32'(snap_en), 32'd1);
    chk("t1_direct_we", 32'(snap_we), 32'd1);
    chk("t1_direct_wbe", 32'(snap_wbe), 32'hF);
    chk("t1_direct_din", snap_din, 32'h1122_3344);
    step(mk(2'b10, 1'b0, 3'd2, 32'h00, 32'h0));
    idle();

    // 2: byte write then back-to-back read of the same word
    step(mk(2'b10, 1'b1, 3'd0, 32'h05, 32'h5566_AB77));
    step(mk(2'b10, 1'b0, 3'd2, 32'h04, 32'h0));
    chk("t2_read_first_we", 32'(snap_we), 32'd0);
    chk("t2_read_first_addr", 32'(snap_addr), 32'd1);
    idle();
    chk("t2_drain_we", 32'(snap_we), 32'd1);
    chk("t2_drain_wbe", 32'(snap_wbe), 32'h2);
    chk("t2_drain_addr", 32'(snap_addr), 32'd1);

    // 3: half write held in buffer across a burst of reads
    step(mk(2'b10, 1'b1, 3'd1, 32'h0A, 32'hBEEF_1234));
    for (int i = 0; i < 5; i++) begin
      step(mk(2'b11, 1'b0, 3'd2, 32'h08, 32'h0));
      chk("t3_no_drain", 32'(snap_we), 32'd0);
    end
    idle();
    chk("t3_drain_we", 32'(snap_we), 32'd1);
    chk("t3_drain_wbe", 32'(snap_wbe), 32'hC);
    chk("t3_drain_addr", 32'(snap_addr), 32'd2);

    // 4: out-of-range read errors without touching SRAM
    step(mk(2'b10, 1'b0, 3'd2, 32'h200, 32'h0));
    chk("t4_no_sram_ap", 32'(snap_en), 32'd0);
    step(mk(2'b10, 1'b0, 3'd2, 32'h00, 32'h0));
    chk("t4_no_sram_err1", 32'(err1_en), 32'd0);
    idle();

    // 5: bad size and misaligned half, then confirm memory untouched
    step(mk(2'b10, 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF));
    step(mk(2'b10, 1'b0, 3'd1, 32'h03, 32'h0));
    step(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    step(mk(2'b10, 1'b0, 3'd2, 32'h00, 32'h0));
    idle();

    // Table vectors: {trans, write, size, addr, wdata, expected error}
    vec[0]  = '{2'b10, 1'b1, 3'd2, 32'h040, 32'hCAFE_F00D, 1'b0};
    vec[1]  = '{2'b10, 1'b0, 3'd2, 32'h040, 32'h0,         1'b0};
    vec[2]  = '{2'b10, 1'b1, 3'd0, 32'h043, 32'h99AA_BBCC, 1'b0};
    vec[3]  = '{2'b11, 1'b0, 3'd0, 32'h040, 32'h0,         1'b0};
    vec[4]  = '{2'b10, 1'b1, 3'd1, 32'h046, 32'h7788_0102, 1'b0};
    vec[5]  = '{2'b11, 1'b0, 3'd2, 32'h044, 32'h0,         1'b0};
    vec[6]  = '{2'b10, 1'b0, 3'd1, 32'h041, 32'h0,         1'b1};
    vec[7]  = '{2'b10, 1'b1, 3'd2, 32'h1FC, 32'h0BAD_C0DE, 1'b0};
    vec[8]  = '{2'b10, 1'b0, 3'd0, 32'h1FF, 32'h0,         1'b0};
    vec[9]  = '{2'b10, 1'b0, 3'd2, 32'h200, 32'h0,         1'b1};
    vec[10] = '{2'b01, 1'b1, 3'd2, 32'h040, 32'h0000_0000, 1'b0};
    for (int i = 0; i <= 10; i++) step(vec[i]);
    idle();
    step(mk(2'b10, 1'b0, 3'd2, 32'h040, 32'h0));
    idle();

    // Random mix over a few words to stress buffering and forwarding
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 15));
      a  = a & ~((32'd1 << sz) - 32'd1);
      if (r == 0)      idle();
      else if (r == 1) step(mk(2'b01, 1'b1, sz, a, $urandom()));
      else if (r == 2) step(mk(2'b10, 1'b1, 3'd3, a, $urandom()));
      else if (r < 6)  step(mk(2'b10, 1'b1, sz, a, $urandom()));
      else             step(mk(2'b11, 1'b0, sz, a, 32'h0));
    end
    idle();
    idle();

    // 6: reset while the buffer holds a write
    saved8 = ref_mem[8];
    step(mk(2'b10, 1'b1, 3'd2, 32'h20, 32'hA5A5_A5A5));
    step(mk(2'b10, 1'b0, 3'd2, 32'h24, 32'h0));
    hsel = 1'b0; htrans = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("t6_rst_hresp", 32'(hresp), 32'd0);
    chk("t6_rst_hrdata", hrdata, 32'h0);
    chk("t6_rst_sram_en", 32'(sram_en), 32'd0);
    sbq.delete();
    err_cyc    = 0;
    ref_mem[8] = saved8;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_buffered_write", mem[8], saved8);
    step(mk(2'b10, 1'b0, 3'd2, 32'h20, 32'h0));
    idle();
    idle();

    // Whole-memory consistency against the reference
    nmis = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_final_mismatches", 32'(nmis), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_sram_if.md
Name: ahb_sram_if

Overview:
- AHB-Lite slave front-end that turns bus transfers into cycles on a single-port, byte-write-enable synchronous SRAM (en/we/wbe[3:0]/addr/din/dout, 1-cycle read latency).
- Sits between the AHB decoder/mux and the SRAM macro.
- Zero wait states for all legal transfers. A single-entry write buffer, with read-forwarding, resolves the write-data-phase vs read-address-phase port conflict.
- Two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_BITS, 7, SRAM word-address width.
- ADDR_AMOUNT, 128, number of SRAM words; legal byte range is 0 to 4*ADDR_AMOUNT-1.
- DATA_BITS, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock (HCLK).
- rst_n  in  1  asynchronous active-low reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  transfer type; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-wide ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- sram_en  out  1  SRAM enable.
- sram_we  out  1  SRAM write (1) / read (0).
- sram_wbe  out  4  byte write enables.
- sram_addr  out  ADDR_BITS  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_dout  in  32  SRAM read data, valid the cycle after a read enable.

Behaviour:
- Reset (async, rst_n=0): hreadyout=1, hresp=0, write buffer empty, data-phase registers idle; hrdata=0, sram_en=0.
- Address phase accepted when hsel & hready & htrans[1]. BUSY and IDLE give an OKAY, zero-wait data phase.
- Byte strobes (little-endian):
  - byte: 1 << haddr[1:0]
  - half: 4'b0011 << haddr[1:0]
  - word: 4'b1111
- Illegal transfer = any of: hsize > 2; half with haddr[0]=1; word with haddr[1:0]!=0; haddr[31:2] >= ADDR_AMOUNT.
  - No SRAM access is made.
  - Data phase: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1.
  - An address phase presented during cycle 2 is accepted normally.
- Read:
  - In the address phase, sram_en=1, sram_we=0, sram_addr=haddr[ADDR_BITS+1:2].
  - Data phase (next cycle): hrdata = sram_dout, with each byte replaced by the buffer byte where buffer valid & buffer address == read word address & buffer strobe set.
  - Full 32-bit word is returned regardless of hsize.
  - hrdata=0 in all non-read data phases.
- Write data phase (registered address and strobes, hwdata live):
  - If no read address phase is accepted in the same cycle: direct write, sram_en=1, sram_we=1, sram_wbe=strobes, sram_din=hwdata.
  - Otherwise: load the buffer (word address, strobes, hwdata) at the clock edge.
- Buffer drain:
  - Trigger: any cycle with the buffer valid and no accepted read address phase.
  - Action: SRAM write from the buffer; buffer clears at the clock edge.
  - This includes the first ERROR cycle.
- Invariants; any violation is an assertion failure:
  - The buffer holds at most one entry; a load while valid cannot occur.
  - A direct write and a drain never coincide.
  - The SRAM port has at most one user per cycle; priority is read address phase > direct write / drain.
- Simultaneous events:
  - Read data phase with a drain in the same cycle: forward from the buffer; the SRAM is updated at the edge.
  - Write data phase to word A together with a read address phase to word A: the SRAM returns old data, the buffer is loaded, and the next-cycle hrdata shows the merged new bytes.
- Reset mid-operation: a pending buffer write is discarded; reset must not be asserted during live traffic.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD
  - HRESP_OKAY/ERROR
  - a strobe-generation function
- Sub-module ahb_sram_wbuf: single-entry buffer (valid, addr, wbe, data), load/drain controls, and the combinational forward-merge output.
- Top level holds the address/data-phase registers, legality check, ERROR FSM (IDLE, ERR1, ERR2), and SRAM port mux.

Test Plan:
1. Reset, then write word 0x11223344 to 0x00, then read 0x00 -> hrdata=0x11223344 with hreadyout=1 throughout; the write goes direct (sram_we=1, wbe=4'hF).
2. Write byte 0xAB to 0x05 followed back-to-back by a read of 0x04 -> the read issues first and the buffer loads; read data phase returns 0x0000AB00 over an SRAM word of 0; the drain writes wbe=4'b0010 the next free cycle.
3. Half write 0xBEEF to 0x0A, then 5 consecutive reads of 0x08 -> the buffer stays valid; every read returns 0xBEEF in bits [31:16]; a trailing IDLE drains it.
4. Word read from 0x200 (ADDR_AMOUNT=128) -> hreadyout 0 then 1, hresp 1,1; no sram_en; a following read of 0x00 completes OKAY.
5. hsize=3 write and a half read at 0x03 -> ERROR response each; SRAM unchanged, as checked by a subsequent read.
6. Assert rst_n low while the buffer is valid -> all outputs return to reset values asynchronously; the buffered write does not reach the SRAM.
